// File: rtl/alu_pkg.sv
// Shared opcode map, FSM states and iterative-unit operation codes for the
// sequential ALU and its bench.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REMU = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_op_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between an ALU client (master) and alu_seq (slave).
interface alu_seq_if #(parameter int unsigned WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aluRes;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, alucontrol, a, b, out_ready,
        input  in_ready, out_valid, aluRes, zero, ovf
    );

    modport slave (
        input  in_valid, alucontrol, a, b, out_ready,
        output in_ready, out_valid, aluRes, zero, ovf
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing one datapath.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  md_op_e           op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    md_op_e           op_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // MUL: acc=product, x=multiplier (shifts right), y=multiplicand (shifts left).
    // DIV: acc=partial remainder, x=dividend shifting into quotient, y=divisor.
    assign trial = {acc_q, x_q[WIDTH-1]};
    assign diff  = trial - {1'b0, y_q};

    always_comb begin
        acc_d = acc_q;
        x_d   = x_q;
        y_d   = y_q;
        if (op_q == MD_MUL) begin
            acc_d = acc_q + (x_q[0] ? y_q : '0);
            x_d   = x_q >> 1;
            y_d   = y_q << 1;
        end else if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = trial[WIDTH-1:0];
            x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
    end

    // Result is taken from the final step's next-state so the caller can
    // register it on the same edge the last step completes.
    assign done_o   = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign result_o = (op_q == MD_DIVU) ? x_d : acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= MD_MUL;
            acc_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            op_q   <= op_i;
            acc_q  <= '0;
            x_q    <= (op_i == MD_MUL) ? b_i : a_i;
            y_q    <= (op_i == MD_MUL) ? a_i : b_i;
        end else if (busy_q) begin
            acc_q <= acc_d;
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: combinational single-cycle ops plus an iterative mul/div unit,
// both feeding one valid/ready result register.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);

    localparam int unsigned SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             iterative;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sum, dif;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    md_op_e           md_op;
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    assign bus.in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign iterative    = is_iterative(bus.alucontrol);
    assign shamt        = bus.b[SW-1:0];
    assign sum          = bus.a + bus.b;
    assign dif          = bus.a - bus.b;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (bus.alucontrol)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_SLL:  sc_res = bus.a << shamt;
            OP_SRL:  sc_res = bus.a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.a) >>> shamt);
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        md_op = MD_MUL;
        if (bus.alucontrol == OP_DIVU) md_op = MD_DIVU;
        if (bus.alucontrol == OP_REMU) md_op = MD_REMU;
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (accept && iterative),
        .op_i     (md_op),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .done_o   (md_done),
        .result_o (md_res)
    );

    // HOLD marks a result stalled by the consumer; consumption alone clears out_valid.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept && iterative) begin
                    state_d     = BUSY;
                    out_valid_d = 1'b0;
                end else if (accept) begin
                    res_d       = sc_res;
                    ovf_d       = sc_ovf;
                    out_valid_d = 1'b1;
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                end else if (out_valid_q) begin
                    state_d = HOLD;
                end
            end
            BUSY: begin
                if (md_done) begin
                    res_d       = md_res;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.aluRes    = res_q;
    assign bus.zero      = (res_q == '0);
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake corner cases
// and randomized operations against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request with bounded waits; returns the result and how many
    // cycles after the accept edge out_valid took, plus in_ready-low cycles.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf, output logic zero,
                         output int lat, output int low);
        int w;
        bus.alucontrol = op;
        bus.a          = a;
        bus.b          = b;
        bus.in_valid   = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin
            tick();
            w++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'd0, 64'd1);
        tick();
        bus.in_valid   = 1'b0;
        bus.a          = ~a;
        bus.b          = ~b;
        bus.alucontrol = 4'hF;
        lat = 0;
        low = 0;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.in_ready) low++;
            tick();
            lat++;
        end
        if (!bus.out_valid) check("result_timeout", 64'd0, 64'd1);
        res  = bus.aluRes;
        ovf  = bus.ovf;
        zero = bus.zero;
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint      s;
        logic [63:0] p;
        r = '0;
        o = 1'b0;
        case (op)
            OP_ADD: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                o = (s != longint'($signed(r)));
            end
            OP_SUB: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                o = (s != longint'($signed(r)));
            end
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            OP_MUL: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
    endfunction

    initial begin
        vec_t        vecs [19];
        logic [31:0] res;
        logic        ovf, zero;
        int          lat, low, explat, cnt;
        logic [3:0]  op;
        logic [31:0] ra, rb, er;
        logic        eo;
        logic        stable, lowok;

        vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1};
        vecs[1]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[2]  = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[3]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[5]  = '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0};
        vecs[7]  = '{OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        vecs[8]  = '{OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0};
        vecs[9]  = '{OP_SLL,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0};
        vecs[10] = '{OP_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
        vecs[11] = '{OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0};
        vecs[12] = '{4'b0000, 32'h0000_0012, 32'h0000_0034, 32'h0000_0000, 1'b0};
        vecs[13] = '{4'b1111, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[14] = '{OP_MUL,  32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 1'b0};
        vecs[15] = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[16] = '{OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[17] = '{OP_REMU, 32'd100,       32'd7,         32'd2,         1'b0};
        vecs[18] = '{OP_REMU, 32'd100,       32'd0,         32'd100,       1'b0};

        bus.in_valid   = 1'b0;
        bus.alucontrol = '0;
        bus.a          = '0;
        bus.b          = '0;
        bus.out_ready  = 1'b1;

        // Reset state
        #3;
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_aluRes",    {32'd0, bus.aluRes},    64'd0);
        check("rst_zero",      {63'd0, bus.zero},      64'd1);
        check("rst_ovf",       {63'd0, bus.ovf},       64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, ovf, zero, lat, low);
            explat = is_iterative(vecs[i].op) ? 32 : 0;
            check($sformatf("vec%0d_res", i),  {32'd0, res},  {32'd0, vecs[i].res});
            check($sformatf("vec%0d_ovf", i),  {63'd0, ovf},  {63'd0, vecs[i].ovf});
            check($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, (vecs[i].res == 0)});
            check($sformatf("vec%0d_lat", i),  64'(lat),      64'(explat));
            check($sformatf("vec%0d_busy_low", i), 64'(low),  64'(explat));
        end

        // Back-to-back SUB, SLT, SLTU with no bubble
        bus.out_ready  = 1'b1;
        bus.alucontrol = OP_SUB;
        bus.a          = 32'd5;
        bus.b          = 32'd5;
        bus.in_valid   = 1'b1;
        check("b2b_ready0", {63'd0, bus.in_ready}, 64'd1);
        tick();
        check("b2b_sub_valid", {63'd0, bus.out_valid}, 64'd1);
        check("b2b_sub_res",   {32'd0, bus.aluRes},    64'd0);
        check("b2b_sub_zero",  {63'd0, bus.zero},      64'd1);
        check("b2b_ready1",    {63'd0, bus.in_ready},  64'd1);
        bus.alucontrol = OP_SLT;
        bus.a          = 32'hFFFF_FFFF;
        bus.b          = 32'd1;
        tick();
        check("b2b_slt_res",  {32'd0, bus.aluRes}, 64'd1);
        check("b2b_slt_zero", {63'd0, bus.zero},   64'd0);
        bus.alucontrol = OP_SLTU;
        tick();
        bus.in_valid = 1'b0;
        check("b2b_sltu_res", {32'd0, bus.aluRes}, 64'd0);
        tick();

        // Consumer stall: result frozen and no accept while out_ready is low
        bus.out_ready = 1'b0;
        do_op(OP_SRA, 32'h8000_0000, 32'h0000_0024, res, ovf, zero, lat, low);
        check("stall_sra_res", {32'd0, res}, 64'hF800_0000);
        bus.alucontrol = OP_ADD;
        bus.a          = 32'd10;
        bus.b          = 32'd20;
        bus.in_valid   = 1'b1;
        stable = 1'b1;
        lowok  = !bus.in_ready;
        repeat (5) begin
            tick();
            if (bus.aluRes !== 32'hF800_0000 || bus.out_valid !== 1'b1 || bus.zero !== 1'b0) stable = 1'b0;
            if (bus.in_ready !== 1'b0) lowok = 1'b0;
        end
        check("stall_stable",   {63'd0, stable}, 64'd1);
        check("stall_no_ready", {63'd0, lowok},  64'd1);
        bus.out_ready = 1'b1;
        do_op(OP_ADD, 32'd10, 32'd20, res, ovf, zero, lat, low);
        check("after_stall_res", {32'd0, res}, 64'd30);

        // Randomized operations against the reference model
        for (int k = 0; k < 150; k++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            model(op, ra, rb, er, eo);
            do_op(op, ra, rb, res, ovf, zero, lat, low);
            explat = is_iterative(op) ? 32 : 0;
            check($sformatf("rnd%0d_op%0h_res", k, op), {32'd0, res},  {32'd0, er});
            check($sformatf("rnd%0d_op%0h_ovf", k, op), {63'd0, ovf},  {63'd0, eo});
            check($sformatf("rnd%0d_zero", k),          {63'd0, zero}, {63'd0, (er == 0)});
            check($sformatf("rnd%0d_lat", k),           64'(lat),      64'(explat));
        end

        // Reset in the middle of a DIVU aborts it
        tick();
        bus.alucontrol = OP_DIVU;
        bus.a          = 32'd1000;
        bus.b          = 32'd3;
        bus.in_valid   = 1'b1;
        cnt = 0;
        while (!bus.in_ready && cnt < 100) begin
            tick();
            cnt++;
        end
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_aluRes",    {32'd0, bus.aluRes},    64'd0);
        check("midrst_zero",      {63'd0, bus.zero},      64'd1);
        check("midrst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.out_valid) cnt++;
        end
        check("midrst_no_result", 64'(cnt), 64'd0);
        do_op(OP_ADD, 32'd2, 32'd3, res, ovf, zero, lat, low);
        check("midrst_add_res", {32'd0, res}, 64'd5);
        check("midrst_add_lat", 64'(lat),     64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
